// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, a registered output entry
// and a one-entry skid buffer, with redirect and in-flight response discard.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instr_out,
    output logic [31:0] PC_out
);

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_discard;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        w_gnt;
    logic        w_rsp;
    logic        w_rsp_keep;
    logic        w_consume;
    logic [31:0] w_redirect_target;

    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_gnt             = imem_req & imem_gnt;
    assign w_rsp             = (r_state == ST_WAIT) & imem_rvalid;
    // A response is dropped if it was killed earlier or a redirect lands with it.
    assign w_rsp_keep        = w_rsp & ~r_discard & ~redirect_valid;
    assign w_consume         = r_out_valid & ~stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_REQ:  if (w_gnt)       w_state_next = ST_WAIT;
            ST_WAIT: if (imem_rvalid) w_state_next = ST_REQ;
            default: w_state_next = ST_REQ;
        endcase
    end

    // r_run holds off the first request until one edge after reset release.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        if ((r_state == ST_REQ) && r_run && !r_skid_valid) begin
            imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_discard     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_gnt) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc      <= w_redirect_target;
                r_discard <= w_gnt | ((r_state == ST_WAIT) & ~imem_rvalid);
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp) begin
                    r_discard <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (redirect_valid) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_instr <= r_skid_instr;
                r_out_pc    <= r_skid_pc;
                if (w_rsp_keep) begin
                    r_skid_instr <= imem_rdata;
                    r_skid_pc    <= r_inflight_pc;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_rsp_keep) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_inflight_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_rsp_keep) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_inflight_pc;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_inflight_pc;
            end
        end
    end

    assign fetch_valid = r_out_valid;
    assign instr_out   = r_out_valid ? r_out_instr : 32'd0;
    assign PC_out      = r_out_valid ? r_out_pc    : 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic against a
// queue-based model of the expected in-order instruction stream.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] instr_out;
    logic [31:0] PC_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: buffered instruction addresses in program order, plus fetch bookkeeping.
    logic [31:0] q[$];
    logic [31:0] m_pc;
    logic [31:0] m_inflight;
    logic        m_out;
    logic        m_killed;
    logic        m_started;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .fetch_valid    (fetch_valid),
        .instr_out      (instr_out),
        .PC_out         (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc       = RESET_PC;
        m_inflight = '0;
        m_out      = 1'b0;
        m_killed   = 1'b0;
        m_started  = 1'b0;
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
    endtask

    // Drive one cycle of inputs, advance to just after the edge, update the model.
    task automatic cyc(input logic s, input logic rd, input logic [31:0] rp,
                       input logic g, input logic v);
        logic req_now;
        logic consume;
        logic grant;
        req_now        = m_started && !m_out && (q.size() < 2);
        stall          = s;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem_gnt       = g;
        imem_rvalid    = v;
        imem_rdata     = v ? mem(m_inflight) : $urandom;
        @(posedge clk);
        #1;
        consume = (q.size() > 0) && !s;
        grant   = req_now && g;
        if (rd) begin
            q.delete();
        end else begin
            if (consume) void'(q.pop_front());
            if (v && !m_killed) q.push_back(m_inflight);
        end
        if (grant) begin
            m_inflight = m_pc;
            m_out      = 1'b1;
            m_killed   = rd;
        end else if (v) begin
            m_out    = 1'b0;
            m_killed = 1'b0;
        end else if (rd && m_out) begin
            m_killed = 1'b1;
        end
        if (rd)         m_pc = {rp[31:2], 2'b00};
        else if (grant) m_pc = m_pc + 32'd4;
        m_started = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv: got %b expected 0", fetch_valid); else n_pass++;
        n_checks++; if (instr_out !== 32'd0) $display("FAIL reset_instr: got %h expected 0", instr_out); else n_pass++;
        n_checks++; if (PC_out !== 32'd0) $display("FAIL reset_pc: got %h expected 0", PC_out); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
        rstn = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL release_req: got %b expected 0", imem_req); else n_pass++;
        #1;
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("FAIL first_addr: got %h expected %h", imem_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_straight();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 1);
            n_checks++; if (fetch_valid !== 1'b1) $display("FAIL straight_fv%0d: got %b expected 1", i, fetch_valid); else n_pass++;
            n_checks++; if (PC_out !== exp_pc) $display("FAIL straight_pc%0d: got %h expected %h", i, PC_out, exp_pc); else n_pass++;
            n_checks++; if (instr_out !== mem(exp_pc)) $display("FAIL straight_instr%0d: got %h expected %h", i, instr_out, mem(exp_pc)); else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (PC_out !== 32'h1C00_0004) $display("FAIL stall_pre: got %h expected 1c000004", PC_out); else n_pass++;
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        n_checks++; if (PC_out !== 32'h1C00_0004) $display("FAIL stall_hold: got %h expected 1c000004", PC_out); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_skid_req: got %b expected 0", imem_req); else n_pass++;
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (fetch_valid !== 1'b1) $display("FAIL stall_fv: got %b expected 1", fetch_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req2: got %b expected 0", imem_req); else n_pass++;
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (PC_out !== 32'h1C00_0008) $display("FAIL stall_skid_out: got %h expected 1c000008", PC_out); else n_pass++;
        n_checks++; if (instr_out !== mem(32'h1C00_0008)) $display("FAIL stall_skid_instr: got %h expected %h", instr_out, mem(32'h1C00_0008)); else n_pass++;
        n_checks++; if (imem_addr !== 32'h1C00_000C || imem_req !== 1'b1) $display("FAIL stall_next_addr: got %b/%h expected 1/1c00000c", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL stall_drain: got %b expected 0", fetch_valid); else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (PC_out !== 32'h1C00_000C) $display("FAIL stall_last: got %h expected 1c00000c", PC_out); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 32'h1C00_0100, 0, 0);
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rdw_flush: got %b expected 0", fetch_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rdw_wait_req: got %b expected 0", imem_req); else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rdw_dropped: got %b expected 0", fetch_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0100) $display("FAIL rdw_addr: got %b/%h expected 1/1c000100", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (fetch_valid !== 1'b1 || PC_out !== 32'h1C00_0100) $display("FAIL rdw_out: got %b/%h expected 1/1c000100", fetch_valid, PC_out); else n_pass++;
        n_checks++; if (instr_out !== mem(32'h1C00_0100)) $display("FAIL rdw_instr: got %h expected %h", instr_out, mem(32'h1C00_0100)); else n_pass++;
    endtask

    task automatic test_redirect_gnt();
        do_reset();
        cyc(0, 1, 32'h1C00_0203, 1, 0);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rdg_wait: got %b expected 0", imem_req); else n_pass++;
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL rdg_dropped: got %b expected 0", fetch_valid); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C00_0200) $display("FAIL rdg_addr: got %b/%h expected 1/1c000200", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (PC_out !== 32'h1C00_0200) $display("FAIL rdg_out: got %h expected 1c000200", PC_out); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h expected fffffffc", imem_addr); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (PC_out !== 32'hFFFF_FFFC) $display("FAIL wrap_out0: got %h expected fffffffc", PC_out); else n_pass++;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) $display("FAIL wrap_addr1: got %b/%h expected 1/00000000", imem_req, imem_addr); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (fetch_valid !== 1'b1 || PC_out !== 32'h0 || instr_out !== mem(32'h0)) $display("FAIL wrap_out1: got %b/%h/%h expected 1/00000000/%h", fetch_valid, PC_out, instr_out, mem(32'h0)); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        n_checks++; if (fetch_valid !== 1'b1) $display("FAIL arst_pre: got %b expected 1", fetch_valid); else n_pass++;
        idle_inputs();
        #3;
        rstn = 1'b0;
        #1;
        n_checks++; if (fetch_valid !== 1'b0 || instr_out !== 32'd0 || PC_out !== 32'd0) $display("FAIL arst_out: got %b/%h/%h expected 0/0/0", fetch_valid, instr_out, PC_out); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL arst_req: got %b expected 0", imem_req); else n_pass++;
        model_reset();
        #2;
        rstn = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL arst_rel_req: got %b expected 0", imem_req); else n_pass++;
        @(posedge clk);
        #1;
        m_started = 1'b1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL arst_addr: got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_random();
        logic        exp_req;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] rp;
        logic        rd;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            exp_req   = m_started && !m_out && (q.size() < 2);
            exp_pc    = (q.size() > 0) ? q[0] : 32'd0;
            exp_instr = (q.size() > 0) ? mem(q[0]) : 32'd0;
            n_checks++; if (fetch_valid !== (q.size() > 0)) $display("FAIL rnd_fv@%0d: got %b expected %b", i, fetch_valid, q.size() > 0); else n_pass++;
            n_checks++; if (PC_out !== exp_pc) $display("FAIL rnd_pc@%0d: got %h expected %h", i, PC_out, exp_pc); else n_pass++;
            n_checks++; if (instr_out !== exp_instr) $display("FAIL rnd_instr@%0d: got %h expected %h", i, instr_out, exp_instr); else n_pass++;
            n_checks++; if (imem_req !== exp_req) $display("FAIL rnd_req@%0d: got %b expected %b", i, imem_req, exp_req); else n_pass++;
            if (exp_req) begin
                n_checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr@%0d: got %h expected %h", i, imem_addr, m_pc); else n_pass++;
            end
            rd = ($urandom % 16) == 0;
            rp = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            cyc(($urandom % 3) == 0, rd, rp, 1'($urandom % 2), m_out && (($urandom % 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
